uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Parametrised, buffered UART transmitter: the next generation of the team's fixed 8-bit, 2-stop-bit serial TX.
- Data width, parity mode, stop-bit count and baud divisor are set at elaboration.
- A FIFO decouples the producer (hash-result formatter) from the serial line. Frames are sent back-to-back with no idle gap while data is queued.
- Sits between the result-output logic and the board TX pin.

Parameters:
CLK_FREQ, 16000000, input clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s; DIV = CLK_FREQ/BAUD_RATE (integer floor), clocks per bit; DIV < 2 is an elaboration error
DATA_BITS, 8, payload bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 16, entries, power of 2, >= 2

Ports:
clock  input  1  system clock
reset  input  1  reset; synchronous, active-high
wr_data  input  DATA_BITS  word to enqueue
wr_valid  input  1  producer offers wr_data
wr_ready  output  1  FIFO not full; a write is accepted on an edge where wr_valid & wr_ready
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently queued (excludes the frame on the line)
busy  output  1  a frame is being shifted (any state other than IDLE)
tx_led  output  1  equals ~busy
tx  output  1  serial line, idle high

Behaviour:
- Reset values (output values after the first edge with reset=1):
  - tx=1, busy=0, tx_led=1, wr_ready=1, fifo_count=0.
  - FSM=IDLE; FIFO pointers cleared, so contents are discarded.
  - Bit counter=0.
- Reset mid-frame: same values after that edge; the frame is aborted and not resumed.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo FIFO_DEPTH.
  - wr_ready = (fifo_count != FIFO_DEPTH), combinational from registered count.
  - A write when full is ignored, even if a pop occurs on the same edge.
  - Simultaneous accepted write and pop leaves the count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Condition: fifo_count != 0.
  - On the next edge: pop the head into the shift register, tx<=0, reload the baud counter with DIV-1, go to START.
  - Latency: a write accepted at edge k into an empty FIFO while IDLE -> count=1 after edge k; pop and tx falls at edge k+1.
- Baud timing:
  - The baud counter decrements each clock; a bit boundary occurs when it reaches 0, then it reloads DIV-1.
  - Every bit, including start, parity and each stop bit, holds tx for exactly DIV clocks.
- START -> DATA at the boundary: tx<=shift[0]; DATA_BITS bits are sent LSB first, shifting right at each boundary.
- After the last data bit's period:
  - PARITY if PARITY != 0, else STOP.
  - Parity bit: odd mode = ~^data; even mode = ^data (total ones including parity is odd/even respectively).
- STOP:
  - tx=1 for STOP_BITS*DIV clocks.
  - At the final boundary: if fifo_count != 0, pop and tx<=0, entering START directly (no idle clock); else go to IDLE, busy<=0.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV clocks, measured from tx falling to the next possible falling edge.
- The shift register holds a private copy of the word; wr_data changes or FIFO writes never alter a frame in flight.
- fifo_count saturates by construction: never exceeds FIFO_DEPTH, never underflows (pop only when non-empty).

Test Plan:
1. CLK_FREQ=1600, BAUD_RATE=100 (DIV=16), 8N1; write 0xA5 while IDLE at edge k -> tx=0 from edge k+1 for 16 clocks, then data bits 1,0,1,0,0,1,0,1 each 16 clocks, then stop=1 for 16 clocks; busy falls 160 clocks after tx fell; tx_led tracks ~busy.
2. PARITY=2, write 0x07 -> parity bit 1, frame 176 clocks. PARITY=1, write 0x07 -> parity bit 0. Write 0x00 with PARITY=1 -> parity bit 1.
3. DIV=16, write 1 byte, wait until busy=1, then write 16 more on consecutive cycles -> fifo_count=16, wr_ready=0; 18th write ignored. Exactly 17 frames follow, the last falling edge 16*160 clocks after the first, with stop bit directly followed by start bit; fifo_count decrements by 1 at each frame start.
4. With FIFO full, hold wr_valid=1 across the edge where STOP ends and a pop occurs -> write rejected on that edge, count becomes 15, wr_ready=1 next cycle; write accepted on the following edge -> count 16.
5. DATA_BITS=7, STOP_BITS=2, PARITY=0, write 0x55 -> start, bits 1,0,1,0,1,0,1, then tx=1 for 32 clocks; frame 160 clocks.
6. Queue 3 bytes, assert reset 50 clocks into the first frame -> next edge tx=1, busy=0, fifo_count=0, wr_ready=1; tx stays 1 for 500 clocks after reset deasserts with no new writes.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with elaboration-time frame format
// Words queue in a circular FIFO; frames are sent back-to-back while data is queued.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 16000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          tx_led,
  output logic                          tx
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [BCW-1:0]       baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 push;
  logic                 pop;
  logic                 boundary;
  logic [DATA_BITS-1:0] head;

  assign wr_ready   = (count_q != CW'(FIFO_DEPTH));
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE);
  assign tx_led     = ~busy;
  assign tx         = tx_q;
  assign head       = mem_q[rd_ptr_q];
  assign boundary   = (baud_q == '0);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    push    = wr_valid && wr_ready;

    if (state_q != S_IDLE) begin
      baud_d = boundary ? BCW'(DIV - 1) : baud_q - BCW'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop = 1'b1;
        end
      end
      S_START: begin
        if (boundary) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (boundary) begin
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (boundary) begin
          tx_d    = 1'b1;
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (boundary) begin
          if (bit_q == 4'(STOP_BITS - 1)) begin
            if (count_q != '0) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Popping always starts a fresh frame, whether from IDLE or straight out of STOP.
    if (pop) begin
      shift_d = head;
      par_d   = (PARITY == 1) ? ~^head : ^head;
      tx_d    = 1'b0;
      baud_d  = BCW'(DIV - 1);
      bit_d   = '0;
      state_d = S_START;
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the cleared pointers make old contents unreachable.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - bench for uart_tx_fifo across four frame formats
// Expected line levels come from a frame-level model: bit lists per word, DIV clocks per bit.
module tb_uart_tx_fifo;

  localparam int DIV = 16;

  logic       clock;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_valid;
  int         sel;
  logic [3:0] wv;
  logic [3:0] rdy_v, busy_v, led_v, tx_v;
  logic [4:0] cnt_v [4];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  assign wv = wr_valid ? (4'd1 << sel) : 4'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  uart_tx_fifo #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16))
    u_dut0 (.clock(clock), .reset(reset), .wr_data(wr_data), .wr_valid(wv[0]), .wr_ready(rdy_v[0]),
            .fifo_count(cnt_v[0]), .busy(busy_v[0]), .tx_led(led_v[0]), .tx(tx_v[0]));
  uart_tx_fifo #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16))
    u_dut1 (.clock(clock), .reset(reset), .wr_data(wr_data), .wr_valid(wv[1]), .wr_ready(rdy_v[1]),
            .fifo_count(cnt_v[1]), .busy(busy_v[1]), .tx_led(led_v[1]), .tx(tx_v[1]));
  uart_tx_fifo #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16))
    u_dut2 (.clock(clock), .reset(reset), .wr_data(wr_data), .wr_valid(wv[2]), .wr_ready(rdy_v[2]),
            .fifo_count(cnt_v[2]), .busy(busy_v[2]), .tx_led(led_v[2]), .tx(tx_v[2]));
  uart_tx_fifo #(.CLK_FREQ(1600), .BAUD_RATE(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16))
    u_dut3 (.clock(clock), .reset(reset), .wr_data(wr_data[6:0]), .wr_valid(wv[3]), .wr_ready(rdy_v[3]),
            .fifo_count(cnt_v[3]), .busy(busy_v[3]), .tx_led(led_v[3]), .tx(tx_v[3]));

  function automatic int cfg_db(int i);
    return (i == 3) ? 7 : 8;
  endfunction

  function automatic int cfg_par(int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction

  function automatic int cfg_stop(int i);
    return (i == 3) ? 2 : 1;
  endfunction

  function automatic int frame_bits(int i);
    return 1 + cfg_db(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_stop(i);
  endfunction

  // Line level of bit slot idx of the frame for word w: start, data LSB first, parity, stops.
  function automatic logic exp_bit(int i, logic [8:0] w, int idx);
    int db   = cfg_db(i);
    int ones = 0;
    for (int k = 0; k < db; k++) ones += int'(w[k]);
    if (idx == 0) return 1'b0;
    if (idx <= db) return w[idx-1];
    if (cfg_par(i) != 0 && idx == db + 1)
      return (cfg_par(i) == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
    return 1'b1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Writes one word into instance i while idle and follows its whole frame clock by clock.
  task automatic send_check(int i, logic [8:0] w);
    int len = frame_bits(i) * DIV;
    @(negedge clock);
    sel      = i;
    wr_data  = w[7:0];
    wr_valid = 1'b1;
    @(negedge clock);
    wr_valid = 1'b0;
    chk($sformatf("u%0d_count_after_write", i), 32'(cnt_v[i]), 32'd1);
    chk($sformatf("u%0d_tx_before_pop", i), 32'(tx_v[i]), 32'd1);
    for (int n = 0; n < len; n++) begin
      @(negedge clock);
      chk($sformatf("u%0d_w%0h_tx_t%0d", i, w, n), 32'(tx_v[i]), 32'(exp_bit(i, w, n / DIV)));
      chk($sformatf("u%0d_busy_t%0d", i, n), 32'(busy_v[i]), 32'd1);
      chk($sformatf("u%0d_led_t%0d", i, n), 32'(led_v[i]), 32'd0);
    end
    @(negedge clock);
    chk($sformatf("u%0d_busy_end", i), 32'(busy_v[i]), 32'd0);
    chk($sformatf("u%0d_led_end", i), 32'(led_v[i]), 32'd1);
    chk($sformatf("u%0d_tx_end", i), 32'(tx_v[i]), 32'd1);
    chk($sformatf("u%0d_count_end", i), 32'(cnt_v[i]), 32'd0);
  endtask

  logic [8:0] frames [18];

  initial begin
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'd0;
    sel      = 0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d_rst_tx", i), 32'(tx_v[i]), 32'd1);
      chk($sformatf("u%0d_rst_busy", i), 32'(busy_v[i]), 32'd0);
      chk($sformatf("u%0d_rst_led", i), 32'(led_v[i]), 32'd1);
      chk($sformatf("u%0d_rst_ready", i), 32'(rdy_v[i]), 32'd1);
      chk($sformatf("u%0d_rst_count", i), 32'(cnt_v[i]), 32'd0);
    end
    reset = 1'b0;

    // Directed frames, then random words on every format.
    send_check(0, 9'h0A5);
    send_check(1, 9'h007);
    send_check(2, 9'h007);
    send_check(2, 9'h000);
    send_check(3, 9'h055);
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 3; r++) begin
        send_check(i, 9'($urandom_range(0, (1 << cfg_db(i)) - 1)));
      end
    end

    // Fill the FIFO behind a frame in flight, overflow it, and write across the pop edge.
    for (int j = 0; j < 18; j++) frames[j] = 9'($urandom_range(0, 255));
    @(negedge clock);
    sel      = 0;
    wr_data  = frames[0][7:0];
    wr_valid = 1'b1;
    @(negedge clock);
    wr_valid = 1'b0;
    @(negedge clock);
    for (int t = 0; t <= 18 * 160 + 2; t++) begin
      int acc;
      int popped;
      logic etx;
      if (t > 0) @(negedge clock);
      etx    = (t / 160 < 18) ? exp_bit(0, frames[t / 160], (t % 160) / DIV) : 1'b1;
      acc    = 1 + ((t < 16) ? t : 16) + ((t >= 161) ? 1 : 0);
      popped = (t / 160 + 1 > 18) ? 18 : t / 160 + 1;
      chk($sformatf("burst_tx_t%0d", t), 32'(tx_v[0]), 32'(etx));
      chk($sformatf("burst_busy_t%0d", t), 32'(busy_v[0]), (t < 18 * 160) ? 32'd1 : 32'd0);
      chk($sformatf("burst_count_t%0d", t), 32'(cnt_v[0]), 32'(acc - popped));
      chk($sformatf("burst_ready_t%0d", t), 32'(rdy_v[0]), (acc - popped == 16) ? 32'd0 : 32'd1);
      if (t < 16) begin
        wr_valid = 1'b1;
        wr_data  = frames[t + 1][7:0];
      end else if (t < 160) begin
        wr_valid = 1'b1;
        wr_data  = 8'($urandom_range(0, 255));
      end else if (t == 160) begin
        wr_valid = 1'b1;
        wr_data  = frames[17][7:0];
      end else begin
        wr_valid = 1'b0;
      end
    end

    // Reset 50 clocks into a frame with two words still queued.
    @(negedge clock);
    sel      = 0;
    wr_valid = 1'b1;
    wr_data  = 8'h3C;
    @(negedge clock);
    wr_data  = 8'hC3;
    @(negedge clock);
    wr_data  = 8'h99;
    @(negedge clock);
    wr_valid = 1'b0;
    repeat (48) @(negedge clock);
    chk("pre_reset_busy", 32'(busy_v[0]), 32'd1);
    chk("pre_reset_count", 32'(cnt_v[0]), 32'd2);
    reset = 1'b1;
    @(negedge clock);
    chk("midreset_tx", 32'(tx_v[0]), 32'd1);
    chk("midreset_busy", 32'(busy_v[0]), 32'd0);
    chk("midreset_led", 32'(led_v[0]), 32'd1);
    chk("midreset_count", 32'(cnt_v[0]), 32'd0);
    chk("midreset_ready", 32'(rdy_v[0]), 32'd1);
    reset = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clock);
      chk($sformatf("post_reset_tx_%0d", n), 32'(tx_v[0]), 32'd1);
      chk($sformatf("post_reset_busy_%0d", n), 32'(busy_v[0]), 32'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
